// File: rtl/storage_bank_if.sv
// Command/status bundle between the button/switch front end and the storage bank.
// The master drives the pushes, switches, serial bit and view index; the slave drives the display/status side.
interface storage_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH);

    logic             record_push;
    logic             transfer_push;
    logic             copy_push;
    logic [WIDTH-1:0] switches;
    logic             serial_in;
    logic [PW-1:0]    view_sel;
    logic [WIDTH-1:0] redled;
    logic [WIDTH-1:0] greenled;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             full;
    logic             busy;
    logic             done;

    modport master (
        output record_push, transfer_push, copy_push, switches, serial_in, view_sel,
        input  redled, greenled, wr_ptr, count, full, busy, done
    );
    modport slave (
        input  record_push, transfer_push, copy_push, switches, serial_in, view_sel,
        output redled, greenled, wr_ptr, count, full, busy, done
    );
endinterface

// File: rtl/storage_bank.sv
// Working "red" register plus a circular bank of stored words, filled either by
// a bit-serial transfer (red rotates out through the target entry) or a parallel copy.
module storage_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    storage_bank_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                       state, state_nx;
    logic [BW-1:0]                bitcnt;
    logic [WIDTH-1:0]             red;
    logic [DEPTH-1:0][WIDTH-1:0]  bank;
    logic [PW-1:0]                wr_ptr;
    logic [PW:0]                  count, count_nx;
    logic                         full, done;
    logic                         do_record, do_transfer, do_copy, last_shift, commit;

    // Commands are only decoded in IDLE; record > transfer > copy.
    always_comb begin
        do_record   = (state == IDLE) && bus.record_push;
        do_transfer = (state == IDLE) && bus.transfer_push && !bus.record_push;
        do_copy     = (state == IDLE) && bus.copy_push && !bus.record_push && !bus.transfer_push;
        last_shift  = (state == SHIFT) && (bitcnt == LAST_BIT);
        commit      = do_copy || last_shift;
        count_nx    = (count == FULL_CNT) ? count : count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (do_transfer) state_nx = SHIFT;
            SHIFT:   if (bitcnt == LAST_BIT) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            red    <= '0;
            bank   <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            bitcnt <= '0;
            done   <= 1'b0;
        end else begin
            done <= last_shift;
            if (do_record)   red    <= bus.switches;
            if (do_transfer) bitcnt <= '0;
            // red drains LSB-first into the top of the target entry while serial_in refills red.
            if (state == SHIFT) begin
                red            <= {bus.serial_in, red[WIDTH-1:1]};
                bank[wr_ptr]   <= {red[0], bank[wr_ptr][WIDTH-1:1]};
                bitcnt         <= bitcnt + 1'b1;
            end
            if (do_copy) bank[wr_ptr] <= red;
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count_nx;
                full   <= (count_nx == FULL_CNT);
            end
        end
    end

    assign bus.redled   = red;
    assign bus.greenled = bank[bus.view_sel];
    assign bus.wr_ptr   = wr_ptr;
    assign bus.count    = count;
    assign bus.full     = full;
    assign bus.done     = done;
endmodule

// File: tb/tb_storage_bank.sv
// Bench for storage_bank: directed vector table, hand sequences for transfer corners,
// then random traffic, all checked against a word-level reference model.
module tb_storage_bank;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int PW   = $clog2(D);
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    storage_bank_if #(.WIDTH(W), .DEPTH(D)) sb ();
    storage_bank #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(sb));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whole words plus a count of bits moved so far.
    int unsigned m_red, m_wp, m_cnt, m_k, m_orig, m_prev, m_sbits;
    int unsigned m_bank [D];
    bit m_busy, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_commit();
        m_wp = (m_wp + 1) % D;
        if (m_cnt < D) m_cnt++;
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_red = 0; m_wp = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_k = 0;
            foreach (m_bank[i]) m_bank[i] = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_sbits |= (int'(sb.serial_in) << m_k);
                m_k++;
                m_red = ((m_orig >> m_k) | (m_sbits << (W - m_k))) & MASK;
                m_bank[m_wp] = ((m_prev >> m_k) | ((m_orig & ((1 << m_k) - 1)) << (W - m_k))) & MASK;
                if (m_k == W) begin
                    model_commit();
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (sb.record_push) begin
                m_red = sb.switches;
            end else if (sb.transfer_push) begin
                m_busy = 1; m_k = 0; m_orig = m_red; m_prev = m_bank[m_wp]; m_sbits = 0;
            end else if (sb.copy_push) begin
                m_bank[m_wp] = m_red;
                model_commit();
            end
        end
    endtask

    task automatic check_all();
        chk("redled", sb.redled, m_red);
        chk("greenled", sb.greenled, m_bank[sb.view_sel]);
        chk("wr_ptr", sb.wr_ptr, m_wp);
        chk("count", sb.count, m_cnt);
        chk("full", sb.full, (m_cnt == D));
        chk("busy", sb.busy, m_busy);
        chk("done", sb.done, m_done);
    endtask

    // One clock edge: model and DUT consume the same inputs, pulses then drop.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        sb.record_push = 0; sb.transfer_push = 0; sb.copy_push = 0;
        reset = 1;
        check_all();
    endtask

    typedef struct {
        logic       rst, rec, tr, cp;
        logic [7:0] sw;
        logic [1:0] vs;
        logic [7:0] e_red, e_green;
        logic [1:0] e_wp;
        logic [2:0] e_cnt;
        logic       e_full, e_busy;
    } vec_t;

    vec_t tv [14];
    int   busycnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sb.record_push = 0; sb.transfer_push = 0; sb.copy_push = 0;
        sb.switches = '0; sb.serial_in = 0; sb.view_sel = '0;

        //         rst rec tr cp  sw     vs  red    green  wp cnt full busy
        tv[0]  = '{0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        tv[2]  = '{1, 1, 0, 0, 8'hA5, 0, 8'hA5, 8'h00, 0, 0, 0, 0};
        tv[3]  = '{1, 1, 0, 0, 8'h11, 0, 8'h11, 8'h00, 0, 0, 0, 0};
        tv[4]  = '{1, 0, 0, 1, 8'h00, 0, 8'h11, 8'h11, 1, 1, 0, 0};
        tv[5]  = '{1, 1, 0, 0, 8'h22, 0, 8'h22, 8'h11, 1, 1, 0, 0};
        tv[6]  = '{1, 0, 0, 1, 8'h00, 1, 8'h22, 8'h22, 2, 2, 0, 0};
        tv[7]  = '{1, 1, 0, 0, 8'h33, 1, 8'h33, 8'h22, 2, 2, 0, 0};
        tv[8]  = '{1, 0, 0, 1, 8'h00, 2, 8'h33, 8'h33, 3, 3, 0, 0};
        tv[9]  = '{1, 1, 0, 0, 8'h44, 2, 8'h44, 8'h33, 3, 3, 0, 0};
        tv[10] = '{1, 0, 0, 1, 8'h00, 3, 8'h44, 8'h44, 0, 4, 1, 0};
        tv[11] = '{1, 1, 0, 0, 8'h55, 3, 8'h55, 8'h44, 0, 4, 1, 0};
        tv[12] = '{1, 0, 0, 1, 8'h00, 0, 8'h55, 8'h55, 1, 4, 1, 0};
        tv[13] = '{1, 1, 1, 1, 8'h3C, 1, 8'h3C, 8'h22, 1, 4, 1, 0};

        for (int i = 0; i < 14; i++) begin
            reset = tv[i].rst;
            sb.record_push = tv[i].rec; sb.transfer_push = tv[i].tr; sb.copy_push = tv[i].cp;
            sb.switches = tv[i].sw; sb.view_sel = tv[i].vs;
            tick();
            chk($sformatf("tv%0d.red", i), sb.redled, tv[i].e_red);
            chk($sformatf("tv%0d.green", i), sb.greenled, tv[i].e_green);
            chk($sformatf("tv%0d.wp", i), sb.wr_ptr, tv[i].e_wp);
            chk($sformatf("tv%0d.cnt", i), sb.count, tv[i].e_cnt);
            chk($sformatf("tv%0d.full", i), sb.full, tv[i].e_full);
            chk($sformatf("tv%0d.busy", i), sb.busy, tv[i].e_busy);
        end

        // Transfer + copy together: transfer wins, no copy.
        sb.transfer_push = 1; sb.copy_push = 1;
        tick();
        chk("trcp.busy", sb.busy, 1);
        chk("trcp.wp", sb.wr_ptr, 1);
        for (int i = 0; i < W; i++) begin
            sb.serial_in = 1'($urandom);
            tick();
        end
        chk("trcp.done", sb.done, 1);
        chk("trcp.entry", sb.greenled, 8'h3C);

        // Serial transfer of A5 with serial_in held high, from a clean reset.
        reset = 0; tick();
        sb.record_push = 1; sb.switches = 8'hA5; tick();
        sb.serial_in = 1; sb.view_sel = 0;
        sb.transfer_push = 1; tick();
        busycnt = 0;
        for (int k = 0; k < 20 && !sb.done; k++) begin
            if (sb.busy) busycnt++;
            tick();
        end
        chk("xfer.busy_cycles", busycnt, W);
        chk("xfer.done", sb.done, 1);
        chk("xfer.bank0", sb.greenled, 8'hA5);
        chk("xfer.red", sb.redled, 8'hFF);
        chk("xfer.wp", sb.wr_ptr, 1);
        chk("xfer.cnt", sb.count, 1);
        tick();
        chk("xfer.done_drop", sb.done, 0);

        // Record and copy pushes at T0+3 are ignored.
        sb.record_push = 1; sb.switches = 8'h5A; tick();
        sb.transfer_push = 1; sb.view_sel = 1; tick();
        tick(); tick();
        sb.record_push = 1; sb.copy_push = 1; sb.switches = 8'hC3; sb.serial_in = 0;
        tick();
        for (int k = 0; k < 20 && !sb.done; k++) begin
            sb.serial_in = 1'($urandom);
            tick();
        end
        chk("busypush.wp", sb.wr_ptr, 2);
        chk("busypush.entry", sb.greenled, 8'h5A);

        // Reset at T0+4 aborts the transfer silently.
        sb.transfer_push = 1; tick();
        tick(); tick(); tick();
        reset = 0; tick();
        chk("midrst.wp", sb.wr_ptr, 0);
        chk("midrst.busy", sb.busy, 0);
        chk("midrst.red", sb.redled, 0);
        for (int k = 0; k < W + 2; k++) begin
            tick();
            chk("midrst.no_done", sb.done, 0);
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            reset            = ($urandom_range(0, 199) != 0);
            sb.record_push   = ($urandom_range(0, 9) == 0);
            sb.transfer_push = ($urandom_range(0, 5) == 0);
            sb.copy_push     = ($urandom_range(0, 4) == 0);
            sb.switches      = W'($urandom);
            sb.serial_in     = 1'($urandom);
            sb.view_sel      = PW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
